// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 field-level instruction encoder with sequential-address output FIFO
// Optional feature: define INSTR_ENCODER_RANGE_CHECK_EN to reject misaligned and out-of-range immediates.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_fmt_i,
  input  logic [6:0]  req_opcode_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [6:0]  req_funct7_i,
  input  logic [31:0] req_imm_i,
  output logic        wr_valid_o,
  input  logic        wr_ready_i,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [1:0] ERR_FMT   = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  logic [31:0] word;
  logic        fmt_illegal;
  logic        bad;
  logic [1:0]  bad_code;

  always_comb begin
    word = 32'h0;
    case (req_fmt_i)
      FMT_R: word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      FMT_I: word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      FMT_S: word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                     req_imm_i[4:0], req_opcode_i};
      FMT_B: word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                     req_imm_i[4:1], req_imm_i[11], req_opcode_i};
      FMT_U: word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
      FMT_J: word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                     req_rd_i, req_opcode_i};
      default: word = 32'h0;
    endcase
  end

  assign fmt_illegal = req_fmt_i[2] & req_fmt_i[1];

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic misaligned;
  logic out_of_range;

  // A value fits an N-bit signed field when every bit above N-2 equals the sign bit.
  always_comb begin
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    case (req_fmt_i)
      FMT_I, FMT_S: out_of_range = !(&req_imm_i[31:11] | ~|req_imm_i[31:11]);
      FMT_B: begin
        misaligned   = req_imm_i[0];
        out_of_range = !(&req_imm_i[31:12] | ~|req_imm_i[31:12]);
      end
      FMT_J: begin
        misaligned   = req_imm_i[0];
        out_of_range = !(&req_imm_i[31:20] | ~|req_imm_i[31:20]);
      end
      FMT_U: misaligned = |req_imm_i[11:0];
      default: begin
        misaligned   = 1'b0;
        out_of_range = 1'b0;
      end
    endcase
  end

  always_comb begin
    bad      = 1'b0;
    bad_code = ERR_FMT;
    if (fmt_illegal) begin
      bad      = 1'b1;
      bad_code = ERR_FMT;
    end else if (misaligned) begin
      bad      = 1'b1;
      bad_code = ERR_ALIGN;
    end else if (out_of_range) begin
      bad      = 1'b1;
      bad_code = ERR_RANGE;
    end
  end
`else
  logic [1:0] unused_codes;
  assign unused_codes = ERR_ALIGN | ERR_RANGE;
  assign bad          = fmt_illegal;
  assign bad_code     = ERR_FMT & ~unused_codes;
`endif

  logic [31:0]      addr_mem [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [31:0]      next_addr;
  logic             full;
  logic             empty;
  logic             accept;
  logic             push;
  logic             pop;
  logic             err_q;
  logic [1:0]       err_code_q;

  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);
  assign req_ready_o = !full & !flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign push        = accept & !bad;
  assign pop         = !empty & wr_ready_i;

  assign wr_valid_o  = !empty;
  assign wr_addr_o   = addr_mem[rd_ptr];
  assign wr_data_o   = data_mem[rd_ptr];
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

  // Storage is reset too so the head register reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (push) begin
      addr_mem[wr_ptr] <= next_addr;
      data_mem[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
    end else if (flush_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      next_addr <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PTR_ONE;
        next_addr <= next_addr + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else if (flush_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & bad;
      if (accept & bad) begin
        err_code_q <= bad_code;
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32 instruction encoder, the inverse of the core's opcode/control decode path. Accepts field-level instruction requests (format, opcode, registers, functs, immediate), packs them into 32-bit instruction words, and emits them as sequential-address write beats for instruction-memory preload or self-test program generation. It sits between the test/boot sequencer and the imem write port, with a small output FIFO to absorb backpressure.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address of the first emitted word and the address after flush.
- `FIFO_DEPTH`, default 4: number of output FIFO entries, power of two, 2..16.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous flush: empties the FIFO and reloads the address counter.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_fmt_i`  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 are illegal.
- `req_opcode_i`  in  7  major opcode, placed verbatim in [6:0].
- `req_rd_i`, `req_rs1_i`, `req_rs2_i`  in  5 each  register indices.
- `req_funct3_i`  in  3; `req_funct7_i`  in  7.
- `req_imm_i`  in  32  immediate as a full signed value. For U it is the final value, so bits [11:0] must be 0.
- `wr_valid_o`  out  1; `wr_ready_i`  in  1  output handshake.
- `wr_addr_o`  out  32  byte address of the word.
- `wr_data_o`  out  32  encoded instruction.
- `err_o`  out  1  one-cycle pulse: a request was rejected.
- `err_code_o`  out  2  0 illegal format, 1 misaligned immediate, 2 immediate out of range; held until the next error.

## Operation
- Accept condition: `req_valid_i & req_ready_o`. Combinational packing follows the standard RV32 R/I/S/B/U/J bit layouts. Fields not used by a format are ignored.
- R format: the immediate is ignored. I format: shifts carry funct7 in `req_imm_i`[11:5].
- Legality checks, applied in this priority order:
  - fmt 6 or 7 → code 0.
  - B or J with imm[0]=1, or U with imm[11:0]≠0 → code 1.
  - I or S with imm outside the 12-bit signed range, B outside 13-bit signed, or J outside 21-bit signed → code 2.
- Legal accepted request: the word is pushed to the FIFO with the current address counter value, and the counter advances by 4. The counter wraps modulo 2^32.
- Rejected request: the request is consumed with no push and no counter change. `err_o` pulses on the following cycle and `err_code_o` is updated.
- `req_ready_o` = !full & !flush_i. It is computed from the registered count, so when full, a same-cycle pop does not allow a push.
- Pop occurs on `wr_valid_o & wr_ready_i`. `wr_valid_o` = !empty. Output data comes from the FIFO head register and is stable while stalled.
- Simultaneous push and pop when not full: count is unchanged and ordering is preserved.
- `flush_i` has priority over push and pop. On the next edge, count=0, the counter is set to `BASE_ADDR`, and any pending `err_o` pulse is cleared.

## Timing
- Reset values: `req_ready_o`=1, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0, `err_o`=0, `err_code_o`=0. Address counter = `BASE_ADDR`, FIFO empty.
- Latency: a request accepted at edge N into an empty FIFO gives `wr_valid_o`=1 in the cycle after edge N.
- Throughput: one word per cycle when `wr_ready_i` is held high.
- Reset asserted mid-stream: all queued words are dropped immediately. No partial beat is emitted after release.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined: the code 1 and code 2 checks are active as described in Operation.
- Not defined:
  - Immediates are silently truncated to each format's field, and the low bits are dropped for B, J and U.
  - Only the illegal-format check (code 0) remains.
  - `err_code_o` can then only take the value 0.

## Test plan
- I, R and S encoding, three back-to-back requests from reset with `wr_ready_i`=1:
  - addi x1,x0,5 → `wr_data_o`=0x00500093 at `BASE_ADDR`.
  - add x3,x1,x2 → 0x002081B3 at +4.
  - sw x2,8(x1) → 0x0020A423 at +8.
- U, B and J encoding:
  - lui x5,0x12345000 → 0x123452B7.
  - beq x0,x0,-4 → 0xFE000EE3.
  - jal x0,0 → 0x0000006F.
- Rejects:
  - B with imm=3 → `err_o` pulse with code 1, no write, next word keeps the same address.
  - I with imm=0x800 → code 2.
  - fmt=7 → code 0.
- Backpressure: with `wr_ready_i`=0, offer 5 requests at FIFO_DEPTH=4. `req_ready_o` drops after the 4th. After releasing, 5 writes appear in order at BASE..BASE+16.
- Flush: queue 3 words, assert `flush_i` for one cycle. Then `wr_valid_o`=0, and the next accepted word goes to `BASE_ADDR`.
- Reset mid-stream: assert `rst_ni`=0 while `wr_valid_o`=1. All outputs reach their reset values asynchronously, and no write occurs after release.
